pe_array_sched: RTL and testbench
=================================

PE_ARRAY_SCHED -- requirements
Module: pe_array_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_PE, default 8, meaning the number of PEs in the chain.
REQ-002 The block SHALL have parameter DW, default 16, meaning the real/imag width; complex word = 2*DW.
REQ-003 The block SHALL have parameter LOAD_NUM, default 16, meaning words loaded per PE.
REQ-004 The block SHALL have parameter ALPHA_NUM, default 8, meaning alpha words output per PE.
REQ-005 The block SHALL have parameter OUT_DEPTH, default 16, meaning output FIFO depth.
REQ-006 The block SHALL have parameter TIMEOUT, default 1023, meaning the maximum idle cycles in RUN.
Ports (one clock; reset is asynchronous and active-low):
REQ-007 The block SHALL have port clk  in  1  clock, all logic on the rising edge.
REQ-008 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-009 The block SHALL have port start  in  1  single-cycle job start.
REQ-010 The block SHALL have ports s_valid in 1 / s_ready out 1 / s_data in 2*DW, the input sample stream (valid/ready).
REQ-011 The block SHALL have ports pe_din_v out NUM_PE / pe_din out 2*DW, a one-hot load strobe and shared load bus to the PEs.
REQ-012 The block SHALL have ports pe_dout_v in NUM_PE / pe_dout in NUM_PE*2*DW, the alpha outputs of the PEs; PE p is at bits [p*2*DW +: 2*DW].
REQ-013 The block SHALL have ports m_valid out 1 / m_ready in 1 / m_data out 2*DW / m_last out 1, the collected alpha stream.
REQ-014 The block SHALL have port busy  out 1, high in any state other than IDLE.
REQ-015 The block SHALL have port done  out 1, a one-cycle pulse at job end.
REQ-016 The block SHALL have port err  out 3, sticky flags: {timeout, overflow, collision}, cleared on start.

Function
REQ-017 The FSM SHALL have the states IDLE, FILL, BURST, RUN and FLUSH.
REQ-018 IDLE: on start, the FSM SHALL go to FILL, with pe_idx=0 and err=0; start in any other state SHALL be ignored.
REQ-019 FILL: s_ready SHALL be 1 while the input buffer (depth LOAD_NUM) is not full, and a beat SHALL be accepted when s_valid&&s_ready; after the LOAD_NUM-th beat is accepted, the next state SHALL be BURST.
REQ-020 BURST: s_ready SHALL be 0, and the block SHALL drive exactly LOAD_NUM consecutive cycles with pe_din_v = one-hot(pe_idx), pe_din = buffer words in arrival order, gapless.
REQ-021 After a burst, pe_idx SHALL increment; if pe_idx < NUM_PE the FSM SHALL go to FILL, else to RUN.
REQ-022 pe_din_v and pe_din SHALL be registered; pe_din SHALL be 0 whenever pe_din_v == 0.
REQ-023 Capture (in BURST and RUN states): each cycle, the lowest-index PE with pe_dout_v set SHALL have its word written to the output FIFO.
REQ-024 If more than one pe_dout_v bit is set in the same cycle, err[0] SHALL be set and the higher-index words dropped.
REQ-025 If the output FIFO is full on capture, err[1] SHALL be set, the word dropped, and out_cnt still incremented.
REQ-026 out_cnt SHALL count captures; when out_cnt reaches NUM_PE*ALPHA_NUM the FSM SHALL go to FLUSH.
REQ-027 RUN: the idle counter SHALL reset on any pe_dout_v bit and increment otherwise.
REQ-028 If the idle counter reaches TIMEOUT, err[2] SHALL be set and the FSM SHALL go to FLUSH.
REQ-029 The m_* interface SHALL follow standard valid/ready: m_data and m_valid are held stable until m_ready; first-word latency is 1 cycle after capture.
REQ-030 m_last SHALL be 1 on the NUM_PE*ALPHA_NUM-th word popped, or on the final word in FLUSH after a timeout.
REQ-031 FLUSH: when the FIFO is empty, done SHALL pulse for 1 cycle and the FSM SHALL go to IDLE.
REQ-032 Simultaneous push and pop on the output FIFO SHALL be allowed at any occupancy, including full.
REQ-033 Counter widths SHALL hold their maximum values without wrap; pe_idx wraps to 0 only at a new start.

Reset
REQ-034 While rst_n=0 the block SHALL be in IDLE, and all outputs SHALL be 0: s_ready, pe_din_v, pe_din, m_valid, m_data, m_last, busy, done, err.
REQ-035 Assertion of rst_n mid-job SHALL abort immediately, empty both buffers, and produce no done pulse.
REQ-036 After reset release, the first start SHALL be honoured on the next rising edge.

Verification
REQ-037 Verification SHALL cover nominal operation: NUM_PE=2, LOAD_NUM=4, ALPHA_NUM=2; start, 8 beats 1..8 -> pe_din_v=01 for 4 cycles with data 1,2,3,4, then 10 for 4 cycles with data 5,6,7,8; PEs return 4 words -> 4 m_data beats in capture order, m_last on the 4th, done pulse, err=0.
REQ-038 Verification SHALL cover an input gap: s_valid low for 3 cycles mid-fill -> burst still gapless, 4 cycles, data order preserved.
REQ-039 Verification SHALL cover collision: pe_dout_v=11 in one cycle -> only PE0 word captured, err=3'b001.
REQ-040 Verification SHALL cover backpressure: m_ready=0 throughout with OUT_DEPTH=2 and 4 captures -> 2 stored, err[1]=1, m_data stable.
REQ-041 Verification SHALL cover timeout: TIMEOUT=10, no pe_dout_v in RUN -> err=3'b100, done 1 cycle after the FIFO empties.
REQ-042 Verification SHALL cover reset mid-BURST: rst_n low for 1 cycle -> pe_din_v=0 immediately, busy=0, no done pulse; a new start runs cleanly.

Source files
------------

// File: rtl/pe_array_sched_if.sv
// pe_array_sched_if: input stream, PE load/alpha buses and output stream of pe_array_sched
interface pe_array_sched_if #(
    parameter int NUM_PE = 8,
    parameter int DW     = 16
);
    logic                     s_valid;
    logic                     s_ready;
    logic [2*DW-1:0]          s_data;
    logic [NUM_PE-1:0]        pe_din_v;
    logic [2*DW-1:0]          pe_din;
    logic [NUM_PE-1:0]        pe_dout_v;
    logic [NUM_PE*2*DW-1:0]   pe_dout;
    logic                     m_valid;
    logic                     m_ready;
    logic [2*DW-1:0]          m_data;
    logic                     m_last;

    // scheduler side
    modport slave (
        input  s_valid, s_data, pe_dout_v, pe_dout, m_ready,
        output s_ready, pe_din_v, pe_din, m_valid, m_data, m_last
    );

    // environment side (sample source, PE chain, alpha sink)
    modport master (
        output s_valid, s_data, pe_dout_v, pe_dout, m_ready,
        input  s_ready, pe_din_v, pe_din, m_valid, m_data, m_last
    );
endinterface

// File: rtl/pe_array_sched.sv
// pe_array_sched: buffers LOAD_NUM samples per PE, bursts them gaplessly onto the
// shared load bus, then collects PE alpha words into an output FIFO.
module pe_array_sched #(
    parameter int NUM_PE    = 8,
    parameter int DW        = 16,
    parameter int LOAD_NUM  = 16,
    parameter int ALPHA_NUM = 8,
    parameter int OUT_DEPTH = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    pe_array_sched_if.slave bus,
    output logic            busy,
    output logic            done,
    output logic [2:0]      err
);
    localparam int CW    = 2 * DW;
    localparam int TOTAL = NUM_PE * ALPHA_NUM;
    localparam int LCW   = $clog2(LOAD_NUM + 1);
    localparam int LAW   = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
    localparam int PCW   = $clog2(NUM_PE + 1);
    localparam int OCW   = $clog2(TOTAL + 1);
    localparam int TCW   = $clog2(TIMEOUT + 1);
    localparam int FAW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FCW   = $clog2(OUT_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, FILL, BURST, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [PCW-1:0]    pe_idx_q, pe_idx_d;
    logic [LCW-1:0]    ld_cnt_q, ld_cnt_d;
    logic [OCW-1:0]    out_cnt_q, out_cnt_d;
    logic [OCW-1:0]    pop_cnt_q, pop_cnt_d;
    logic [TCW-1:0]    idle_q, idle_d;
    logic [2:0]        err_q, err_d;
    logic              done_q, done_d;
    logic [NUM_PE-1:0] pe_din_v_q, pe_din_v_d;
    logic [CW-1:0]     pe_din_q, pe_din_d;
    logic [FAW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FAW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic [CW-1:0]     in_buf_q [LOAD_NUM];
    logic [CW-1:0]     fifo_q   [OUT_DEPTH];

    logic              s_ready, m_valid;
    logic              in_acc, cap_v, cap_multi, cap_en, fifo_full, push, pop;
    logic [CW-1:0]     cap_word;

    assign s_ready   = (state_q == FILL) && (ld_cnt_q < LCW'(LOAD_NUM));
    assign m_valid   = (fcnt_q != '0);
    assign in_acc    = bus.s_valid && s_ready;
    assign cap_en    = cap_v && ((state_q == BURST) || (state_q == RUN));
    assign pop       = m_valid && bus.m_ready;
    assign fifo_full = (fcnt_q == FCW'(OUT_DEPTH));
    // a full FIFO still accepts a word when the head leaves in the same cycle
    assign push      = cap_en && (!fifo_full || pop);

    // priority pick: lowest-index PE with a valid alpha word wins, others flag a collision
    always_comb begin
        cap_v     = 1'b0;
        cap_multi = 1'b0;
        cap_word  = '0;
        for (int unsigned p = 0; p < NUM_PE; p++) begin
            if (bus.pe_dout_v[p]) begin
                if (cap_v) begin
                    cap_multi = 1'b1;
                end else begin
                    cap_v    = 1'b1;
                    cap_word = bus.pe_dout[p*CW +: CW];
                end
            end
        end
    end

    // job sequencing: next state, counters, sticky errors and load-bus drive
    always_comb begin
        state_d    = state_q;
        pe_idx_d   = pe_idx_q;
        ld_cnt_d   = ld_cnt_q;
        out_cnt_d  = out_cnt_q;
        pop_cnt_d  = pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
        idle_d     = idle_q;
        err_d      = err_q;
        done_d     = 1'b0;
        pe_din_v_d = '0;
        pe_din_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    pe_idx_d  = '0;
                    ld_cnt_d  = '0;
                    out_cnt_d = '0;
                    pop_cnt_d = '0;
                    idle_d    = '0;
                    err_d     = '0;
                end
            end
            FILL: begin
                if (in_acc) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == LCW'(LOAD_NUM - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = BURST;
                    end
                end
            end
            BURST: begin
                pe_din_v_d = NUM_PE'(1) << pe_idx_q;
                pe_din_d   = in_buf_q[ld_cnt_q[LAW-1:0]];
                ld_cnt_d   = ld_cnt_q + 1'b1;
                if (ld_cnt_q == LCW'(LOAD_NUM - 1)) begin
                    ld_cnt_d = '0;
                    idle_d   = '0;
                    pe_idx_d = pe_idx_q + 1'b1;
                    state_d  = (pe_idx_d < PCW'(NUM_PE)) ? FILL : RUN;
                end
            end
            RUN: begin
                idle_d = (|bus.pe_dout_v) ? '0 : idle_q + 1'b1;
                if (idle_d == TCW'(TIMEOUT)) begin
                    err_d[2] = 1'b1;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // capture bookkeeping overrides the per-state decision once all alphas are in
        if (cap_en) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (cap_multi) err_d[0] = 1'b1;
            if (fifo_full && !pop) err_d[1] = 1'b1;
            if (out_cnt_q == OCW'(TOTAL - 1)) state_d = FLUSH;
        end
    end

    // output FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == FAW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == FAW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        fcnt_d = fcnt_q + FCW'(push) - FCW'(pop);
    end

    // control state register; reset aborts the job and empties both buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pe_idx_q   <= '0;
            ld_cnt_q   <= '0;
            out_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            idle_q     <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            pe_din_v_q <= '0;
            pe_din_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pe_idx_q   <= pe_idx_d;
            ld_cnt_q   <= ld_cnt_d;
            out_cnt_q  <= out_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
            done_q     <= done_d;
            pe_din_v_q <= pe_din_v_d;
            pe_din_q   <= pe_din_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // storage arrays; contents are only meaningful behind the counters, so no reset
    always_ff @(posedge clk) begin
        if (in_acc) in_buf_q[ld_cnt_q[LAW-1:0]] <= bus.s_data;
        if (push)   fifo_q[wr_ptr_q]           <= cap_word;
    end

    assign bus.s_ready  = s_ready;
    assign bus.pe_din_v = pe_din_v_q;
    assign bus.pe_din   = pe_din_q;
    assign bus.m_valid  = m_valid;
    assign bus.m_data   = m_valid ? fifo_q[rd_ptr_q] : '0;
    assign bus.m_last   = m_valid && ((pop_cnt_q == OCW'(TOTAL - 1)) ||
                                      ((state_q == FLUSH) && err_q[2] && (fcnt_q == FCW'(1))));
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_pe_array_sched.sv
// tb_pe_array_sched: directed scenarios for pe_array_sched with NUM_PE=2, LOAD_NUM=4,
// ALPHA_NUM=2, OUT_DEPTH=2, TIMEOUT=10.
module tb_pe_array_sched;
    localparam int NUM_PE    = 2;
    localparam int DW        = 16;
    localparam int LOAD_NUM  = 4;
    localparam int ALPHA_NUM = 2;
    localparam int OUT_DEPTH = 2;
    localparam int TIMEOUT   = 10;
    localparam int CW        = 2 * DW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [2:0] err;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    pe_array_sched_if #(.NUM_PE(NUM_PE), .DW(DW)) bus ();

    pe_array_sched #(
        .NUM_PE(NUM_PE), .DW(DW), .LOAD_NUM(LOAD_NUM),
        .ALPHA_NUM(ALPHA_NUM), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic present(input logic [NUM_PE-1:0] v, input logic [CW-1:0] w0, input logic [CW-1:0] w1);
        bus.pe_dout_v = v;
        bus.pe_dout   = {w1, w0};
    endtask

    // feeds LOAD_NUM consecutive beats base, base+1, ...
    task automatic fill(input logic [CW-1:0] base);
        logic acc;
        int   w;
        for (int i = 0; i < LOAD_NUM; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = base + CW'(i);
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 20) begin
                acc = bus.s_ready;
                tick();
                w++;
            end
            if (!acc) begin
                total_cnt++;
                $display("FAIL fill_accept: beat %0d s_ready=%b want 1", i, bus.s_ready);
            end
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic load_pe(input logic [CW-1:0] base);
        fill(base);
        repeat (LOAD_NUM) tick();
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        present('0, '0, '0);
        rst_n = 1'b0;
        repeat (2) tick();
        total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); else pass_cnt++;
        total_cnt++; if (bus.pe_din_v !== 2'b00) $display("FAIL rst_pe_din_v: got %b want 00", bus.pe_din_v); else pass_cnt++;
        total_cnt++; if (bus.pe_din !== 32'h0) $display("FAIL rst_pe_din: got %h want 0", bus.pe_din); else pass_cnt++;
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); else pass_cnt++;
        total_cnt++; if (bus.m_data !== 32'h0) $display("FAIL rst_m_data: got %h want 0", bus.m_data); else pass_cnt++;
        total_cnt++; if (bus.m_last !== 1'b0) $display("FAIL rst_m_last: got %b want 0", bus.m_last); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (err !== 3'b000) $display("FAIL rst_err: got %b want 000", err); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_no_start_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_nominal();
        logic [CW-1:0] w [4];
        w[0] = 32'hA000_0001; w[1] = 32'hB000_0002; w[2] = 32'hA000_0003; w[3] = 32'hB000_0004;
        bus.m_ready = 1'b1;
        pulse_start();
        total_cnt++; if (busy !== 1'b1) $display("FAIL nom_busy_after_start: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL nom_s_ready_fill: got %b want 1", bus.s_ready); else pass_cnt++;
        fill(32'd1);
        total_cnt++; if ({bus.pe_din_v, bus.pe_din} !== {2'b00, 32'h0}) $display("FAIL nom_pre_burst: got %b/%h want 00/0", bus.pe_din_v, bus.pe_din); else pass_cnt++;
        for (int k = 0; k < LOAD_NUM; k++) begin
            tick();
            total_cnt++;
            if ({bus.pe_din_v, bus.pe_din} !== {2'b01, 32'(k + 1)})
                $display("FAIL nom_burst0[%0d]: got %b/%h want 01/%h", k, bus.pe_din_v, bus.pe_din, 32'(k + 1));
            else pass_cnt++;
        end
        fill(32'd5);
        for (int k = 0; k < LOAD_NUM; k++) begin
            tick();
            total_cnt++;
            if ({bus.pe_din_v, bus.pe_din} !== {2'b10, 32'(k + 5)})
                $display("FAIL nom_burst1[%0d]: got %b/%h want 10/%h", k, bus.pe_din_v, bus.pe_din, 32'(k + 5));
            else pass_cnt++;
        end
        tick();
        total_cnt++; if ({bus.pe_din_v, bus.pe_din} !== {2'b00, 32'h0}) $display("FAIL nom_post_burst: got %b/%h want 00/0", bus.pe_din_v, bus.pe_din); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) present(2'b01, w[k], 32'h0);
            else            present(2'b10, 32'h0, w[k]);
            tick();
            total_cnt++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, w[k], (k == 3)})
                $display("FAIL nom_out[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, bus.m_valid, bus.m_data, bus.m_last, w[k], (k == 3));
            else pass_cnt++;
        end
        present('0, '0, '0);
        tick();
        total_cnt++; if ({bus.m_valid, done} !== 2'b00) $display("FAIL nom_drain: got v=%b done=%b want 0/0", bus.m_valid, done); else pass_cnt++;
        tick();
        total_cnt++; if ({done, busy, err} !== {1'b1, 1'b0, 3'b000}) $display("FAIL nom_done: got done=%b busy=%b err=%b want 1/0/000", done, busy, err); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL nom_done_width: got %b want 0", done); else pass_cnt++;
    endtask

    // leaves the job in FILL for PE1; test_collision continues it
    task automatic test_input_gap();
        bus.m_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < LOAD_NUM; i++) begin
            if (i == 2) begin
                bus.s_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    tick();
                    total_cnt++;
                    if ({bus.s_ready, bus.pe_din_v} !== {1'b1, 2'b00})
                        $display("FAIL gap_hold[%0d]: got s_ready=%b pe_din_v=%b want 1/00", g, bus.s_ready, bus.pe_din_v);
                    else pass_cnt++;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h11 + 32'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        for (int k = 0; k < LOAD_NUM; k++) begin
            tick();
            total_cnt++;
            if ({bus.pe_din_v, bus.pe_din} !== {2'b01, 32'h11 + 32'(k)})
                $display("FAIL gap_burst[%0d]: got %b/%h want 01/%h", k, bus.pe_din_v, bus.pe_din, 32'h11 + 32'(k));
            else pass_cnt++;
        end
    endtask

    task automatic test_collision();
        load_pe(32'h15);
        present(2'b11, 32'hC000_0000, 32'hD000_0001);
        tick();
        total_cnt++; if (bus.m_data !== 32'hC000_0000) $display("FAIL col_word: got %h want c0000000", bus.m_data); else pass_cnt++;
        total_cnt++; if (err !== 3'b001) $display("FAIL col_err: got %b want 001", err); else pass_cnt++;
        present(2'b10, 32'h0, 32'hC000_0011);
        tick();
        total_cnt++; if (bus.m_data !== 32'hC000_0011) $display("FAIL col_next: got %h want c0000011", bus.m_data); else pass_cnt++;
        present(2'b01, 32'hC000_0012, 32'h0);
        tick();
        total_cnt++; if ({bus.m_data, bus.m_last} !== {32'hC000_0012, 1'b0}) $display("FAIL col_third: got %h/%b want c0000012/0", bus.m_data, bus.m_last); else pass_cnt++;
        present(2'b10, 32'h0, 32'hC000_0013);
        tick();
        total_cnt++; if ({bus.m_data, bus.m_last} !== {32'hC000_0013, 1'b1}) $display("FAIL col_last: got %h/%b want c0000013/1", bus.m_data, bus.m_last); else pass_cnt++;
        present('0, '0, '0);
        tick();
        tick();
        total_cnt++; if ({done, err} !== {1'b1, 3'b001}) $display("FAIL col_done: got done=%b err=%b want 1/001", done, err); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] w [4];
        w[0] = 32'hE000_0001; w[1] = 32'hE000_0002; w[2] = 32'hE000_0003; w[3] = 32'hE000_0004;
        bus.m_ready = 1'b0;
        pulse_start();
        load_pe(32'h31);
        load_pe(32'h35);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) present(2'b01, w[k], 32'h0);
            else            present(2'b10, 32'h0, w[k]);
            tick();
            total_cnt++;
            if ({bus.m_valid, bus.m_data} !== {1'b1, w[0]})
                $display("FAIL bp_stable[%0d]: got v=%b d=%h want 1/%h", k, bus.m_valid, bus.m_data, w[0]);
            else pass_cnt++;
            total_cnt++;
            if (err !== ((k >= 2) ? 3'b010 : 3'b000))
                $display("FAIL bp_err[%0d]: got %b want %b", k, err, ((k >= 2) ? 3'b010 : 3'b000));
            else pass_cnt++;
        end
        present('0, '0, '0);
        bus.m_ready = 1'b1;
        tick();
        total_cnt++; if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, w[1], 1'b0}) $display("FAIL bp_second: got v=%b d=%h l=%b want 1/%h/0", bus.m_valid, bus.m_data, bus.m_last, w[1]); else pass_cnt++;
        tick();
        total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", bus.m_valid); else pass_cnt++;
        tick();
        total_cnt++; if ({done, err} !== {1'b1, 3'b010}) $display("FAIL bp_done: got done=%b err=%b want 1/010", done, err); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        bus.m_ready = 1'b0;
        pulse_start();
        load_pe(32'h41);
        load_pe(32'h45);
        present(2'b01, 32'hF000_0001, 32'h0);
        tick();
        present('0, '0, '0);
        total_cnt++; if ({bus.m_valid, bus.m_last} !== 2'b10) $display("FAIL to_capture: got v=%b l=%b want 1/0", bus.m_valid, bus.m_last); else pass_cnt++;
        repeat (TIMEOUT - 1) tick();
        total_cnt++; if ({busy, err, bus.m_last} !== {1'b1, 3'b000, 1'b0}) $display("FAIL to_before: got busy=%b err=%b l=%b want 1/000/0", busy, err, bus.m_last); else pass_cnt++;
        tick();
        total_cnt++; if (err !== 3'b100) $display("FAIL to_err: got %b want 100", err); else pass_cnt++;
        total_cnt++; if ({bus.m_data, bus.m_last} !== {32'hF000_0001, 1'b1}) $display("FAIL to_last: got %h/%b want f0000001/1", bus.m_data, bus.m_last); else pass_cnt++;
        bus.m_ready = 1'b1;
        tick();
        total_cnt++; if ({bus.m_valid, done} !== 2'b00) $display("FAIL to_drain: got v=%b done=%b want 0/0", bus.m_valid, done); else pass_cnt++;
        tick();
        total_cnt++; if ({done, busy} !== 2'b10) $display("FAIL to_done: got done=%b busy=%b want 1/0", done, busy); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL to_done_width: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        bus.m_ready = 1'b1;
        pulse_start();
        fill(32'h51);
        tick();
        tick();
        total_cnt++; if ({bus.pe_din_v, bus.pe_din} !== {2'b01, 32'h52}) $display("FAIL rmb_in_burst: got %b/%h want 01/52", bus.pe_din_v, bus.pe_din); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({bus.pe_din_v, bus.pe_din, busy} !== {2'b00, 32'h0, 1'b0}) $display("FAIL rmb_abort: got v=%b d=%h busy=%b want 00/0/0", bus.pe_din_v, bus.pe_din, busy); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({done, busy} !== 2'b00) $display("FAIL rmb_quiet[%0d]: got done=%b busy=%b want 0/0", i, done, busy);
            else pass_cnt++;
        end
        test_nominal();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_input_gap();
        test_collision();
        test_backpressure();
        test_timeout();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
